// File: rtl/integrador_pkg.sv
// Shared constants, FSM state type and the overflow clamp used by integrador_v2.
package integrador_pkg;

   localparam int DATA_W    = 16;
   localparam int PROD_W    = 32;
   localparam int MUL_STEPS = 16;
   localparam int SUM_W     = PROD_W + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      ACC  = 2'd2
   } state_t;

   // Clamp a 33-bit signed sum into the signed 16-bit range.
   function automatic logic [DATA_W-1:0] sat16(input logic signed [SUM_W-1:0] s);
      logic [DATA_W-1:0] r;
      if (s > $signed(SUM_W'(32767)))
         r = 16'h7FFF;
      else if (s < -$signed(SUM_W'(32768)))
         r = 16'h8000;
      else
         r = s[DATA_W-1:0];
      return r;
   endfunction

endpackage

// File: rtl/integrador_seqmul.sv
// Sequential 16x16 unsigned shift-add multiplier, one partial product per cycle.
// start loads the operands; MUL_STEPS cycles later product holds the result.
// done is combinational: high in the cycle whose closing edge performs the
// final iteration, so a consumer sampling done sees product valid next cycle.
module integrador_seqmul
   import integrador_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] op_a,
   input  logic [DATA_W-1:0] op_b,
   output logic [PROD_W-1:0] product,
   output logic              done
);

   logic [PROD_W-1:0] mcand;
   logic [DATA_W-1:0] mplier;
   logic [3:0]        cnt;
   logic              running;

   // Load operands on start, then add one shifted multiplicand per cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         mcand   <= '0;
         mplier  <= '0;
         cnt     <= '0;
         running <= 1'b0;
         product <= '0;
      end else if (start) begin
         mcand   <= {{(PROD_W-DATA_W){1'b0}}, op_a};
         mplier  <= op_b;
         cnt     <= '0;
         running <= 1'b1;
         product <= '0;
      end else if (running) begin
         if (mplier[0])
            product <= product + mcand;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt + 4'd1;
         if (cnt == 4'(MUL_STEPS-1))
            running <= 1'b0;
      end
   end

   assign done = running && (cnt == 4'(MUL_STEPS-1));

endmodule

// File: rtl/integrador_v2.sv
// Fixed-point integrator: v += (a*dt) >>> FRAC_BITS, one step per 18 cycles.
// Handshake: a step is accepted on a rising edge that samples enable=1 while
// busy=0; a, dt and enable are ignored from then until busy falls, which is
// the same edge that writes the new v.
// Optional feature: define INTEGRADOR_SAT_EN to clamp v on overflow instead
// of wrapping.
module integrador_v2
   import integrador_pkg::*;
#(
   parameter int FRAC_BITS = 0
)(
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] dt,
   input  logic              enable,
   output logic [DATA_W-1:0] v,
   output logic              busy
);

   state_t state, state_next;

   logic                     start;
   logic                     a_neg;
   logic [DATA_W-1:0]        a_mag;
   logic [PROD_W-1:0]        product;
   logic                     mul_done;
   logic signed [SUM_W-1:0]  prod_s;
   logic signed [SUM_W-1:0]  scaled;
   logic signed [SUM_W-1:0]  sum;
   logic [DATA_W-1:0]        v_next;

   // |a| in 16 unsigned bits; 0x8000 maps to 32768 without overflow.
   assign a_mag = a[DATA_W-1] ? DATA_W'(~a + 16'd1) : a;

   integrador_seqmul u_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .op_a    (a_mag),
      .op_b    (dt),
      .product (product),
      .done    (mul_done)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_next;
   end

   // Next-state logic and multiplier start strobe.
   always_comb begin
      state_next = state;
      start      = 1'b0;
      case (state)
         IDLE: begin
            if (enable) begin
               start      = 1'b1;
               state_next = MUL;
            end
         end
         MUL: begin
            if (mul_done)
               state_next = ACC;
         end
         ACC: begin
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Re-apply the sign, scale by FRAC_BITS (floor) and form the 33-bit sum.
   always_comb begin
      prod_s = {1'b0, product};
      if (a_neg)
         prod_s = -prod_s;
      scaled = prod_s >>> FRAC_BITS;
      sum    = $signed({{(SUM_W-DATA_W){v[DATA_W-1]}}, v}) + scaled;
   end

`ifdef INTEGRADOR_SAT_EN
   assign v_next = sat16(sum);
`else
   logic unused_sum_hi;
   assign unused_sum_hi = ^sum[SUM_W-1:DATA_W];
   assign v_next = sum[DATA_W-1:0];
`endif

   // Busy flag, captured sign and the integral register.
   always_ff @(posedge clk) begin
      if (rst) begin
         v     <= '0;
         busy  <= 1'b0;
         a_neg <= 1'b0;
      end else begin
         if (start) begin
            busy  <= 1'b1;
            a_neg <= a[DATA_W-1];
         end
         if (state == ACC) begin
            v    <= v_next;
            busy <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_integrador_v2.sv
// Self-checking bench for integrador_v2: two instances (FRAC_BITS=0 and 8)
// share the same stimulus and are compared against an arithmetic model.
module tb_integrador_v2;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic [15:0] a;
   logic [15:0] dt;
   logic [15:0] v0, v8;
   logic        busy0, busy8;

   int checks   = 0;
   int failures = 0;

   logic [15:0] mv0, mv8;
   logic [15:0] exp_q[$];

   always #5 clk = ~clk;

   integrador_v2 #(.FRAC_BITS(0)) u_dut0 (
      .clk(clk), .rst(rst), .a(a), .dt(dt), .enable(enable), .v(v0), .busy(busy0)
   );

   integrador_v2 #(.FRAC_BITS(8)) u_dut8 (
      .clk(clk), .rst(rst), .a(a), .dt(dt), .enable(enable), .v(v8), .busy(busy8)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Reference: exact signed product, floor shift, then clamp or wrap.
   function automatic logic [15:0] ref_step(input logic [15:0] vin, input logic [15:0] ai,
                                           input logic [15:0] dti, input int frac);
      longint p, s;
      p = longint'($signed(ai)) * longint'({48'd0, dti});
      p = p >>> frac;
      s = longint'($signed(vin)) + p;
`ifdef INTEGRADOR_SAT_EN
      if (s > 32767) s = 32767;
      else if (s < -32768) s = -32768;
`endif
      return s[15:0];
   endfunction

   task automatic do_reset(input int n);
      @(negedge clk);
      rst = 1'b1; enable = 1'b0;
      repeat (n) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      mv0 = '0; mv8 = '0;
      check("rst_v0", v0, 0);
      check("rst_v8", v8, 0);
      check("rst_busy0", busy0, 0);
      check("rst_busy8", busy8, 0);
   endtask

   // mode 0: drop enable after accept; 1: hold enable and operands; 2: random noise on inputs.
   task automatic run_step(input logic [15:0] sa, input logic [15:0] sdt, input int mode);
      @(negedge clk);
      a = sa; dt = sdt; enable = 1'b1;
      exp_q.push_back(ref_step(mv0, sa, sdt, 0));
      exp_q.push_back(ref_step(mv8, sa, sdt, 8));
      @(posedge clk); #1;
      check("busy_accept0", busy0, 1);
      check("busy_accept8", busy8, 1);
      for (int c = 1; c <= 16; c++) begin
         @(negedge clk);
         if (mode == 2) begin
            enable = 1'($urandom_range(0, 1));
            a      = 16'($urandom);
            dt     = 16'($urandom);
         end else if (mode == 0) begin
            enable = 1'b0;
         end
         @(posedge clk); #1;
         check("busy_mid", busy0, 1);
         if (c == 16) begin
            check("v_hold0", v0, mv0);
            check("v_hold8", v8, mv8);
         end
      end
      @(negedge clk);
      if (mode != 1) enable = 1'b0;
      @(posedge clk); #1;
      mv0 = exp_q.pop_front();
      mv8 = exp_q.pop_front();
      check("v_f0", v0, mv0);
      check("v_f8", v8, mv8);
      check("busy_fall0", busy0, 0);
      check("busy_fall8", busy8, 0);
   endtask

   task automatic check_idle(input int n);
      @(negedge clk);
      enable = 1'b0;
      repeat (n) @(posedge clk);
      #1;
      check("idle_busy", busy0, 0);
      check("idle_v0", v0, mv0);
   endtask

   initial begin
      rst = 1'b1; enable = 1'b0; a = '0; dt = '0;
      mv0 = '0; mv8 = '0;
      do_reset(10);

      // Back-to-back steps with enable held: 100 then 200, accept every 18 edges.
      run_step(16'd10, 16'd10, 1);
      check("req030_v1", v0, 16'd100);
      run_step(16'd10, 16'd10, 1);
      check("req030_v2", v0, 16'd200);
      check_idle(2);

      // Negative rate.
      do_reset(2);
      run_step(16'hFFFB, 16'd4, 0);
      check("neg_v1", v0, 16'hFFEC);
      run_step(16'hFFFB, 16'd4, 0);
      check("neg_v2", v0, 16'hFFD8);

      // Large product overflow handling.
      do_reset(2);
      run_step(16'h7FFF, 16'hFFFF, 0);
`ifdef INTEGRADOR_SAT_EN
      check("ovf_v", v0, 16'h7FFF);
`else
      check("ovf_v", v0, 16'h8001);
`endif

      // Inputs changing mid-step must not matter, nor start an extra step.
      do_reset(2);
      run_step(16'd3, 16'd2, 2);
      check("noise_v", v0, 16'd6);
      check_idle(3);

      // Reset mid-step aborts with no later update.
      run_step(16'd10, 16'd10, 0);
      @(negedge clk);
      a = 16'd7; dt = 16'd9; enable = 1'b1;
      @(posedge clk);
      @(negedge clk);
      enable = 1'b0;
      repeat (7) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      check("midrst_busy", busy0, 0);
      check("midrst_v", v0, 0);
      @(negedge clk);
      rst = 1'b0;
      mv0 = '0; mv8 = '0;
      repeat (25) @(posedge clk);
      #1;
      check("midrst_after_v", v0, 0);
      check("midrst_after_busy", busy0, 0);

      // Fractional scaling on the FRAC_BITS=8 instance.
      do_reset(2);
      run_step(16'h0100, 16'h0080, 0);
      check("frac_v1", v8, 16'h0080);
      run_step(16'hFF00, 16'h0080, 0);
      check("frac_v2", v8, 16'h0000);

      // Zero operands and most-negative a.
      run_step(16'h0000, 16'h1234, 0);
      run_step(16'h4321, 16'h0000, 0);
      do_reset(2);
      run_step(16'h8000, 16'd1, 0);
      check("minneg_v", v0, 16'h8000);
      run_step(16'h8000, 16'hFFFF, 2);

      // Random steps.
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 3) == 0)
            run_step(16'($urandom), 16'($urandom_range(0, 65535)), int'($urandom_range(0, 2)));
         else
            run_step(16'($urandom_range(0, 400)) - 16'd200, 16'($urandom_range(0, 300)),
                     int'($urandom_range(0, 2)));
      end
      check_idle(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
